feature_map_stream_reader: RTL and testbench

- Sits on the output side of the 3x3 stride-1 padding-1 convolution layer.
- Captures one full IMG_WIDHT x IMG_HEIGHT result frame from the Data_Out/Valid_Out stream (no backpressure) into an internal frame buffer.
- Replays the frame in raster order to the next layer over a valid/ready stream.
- Decouples the convolution from a downstream consumer that may stall.

---
 rtl/feature_map_stream_reader_pkg.sv | 21 ++
 rtl/feature_map_stream_reader_frame_buffer_ram.sv | 26 ++
 rtl/feature_map_stream_reader.sv | 142 ++++++++++++++
 tb/tb_feature_map_stream_reader.sv | 219 +++++++++++++++++++++
 4 files changed

// File: rtl/feature_map_stream_reader_pkg.sv
// Shared CNN definitions: replay FSM states, pixel width default
// and an elaboration-time clog2 helper.
package feature_map_stream_reader_pkg;

   localparam int DATA_WIDHT_DFLT = 32;

   typedef enum logic [1:0] {
      FILL  = 2'd0,
      FULL  = 2'd1,
      DRAIN = 2'd2
   } state_t;

   function automatic int clog2(input int v);
      int r;
      r = 0;
      for (int i = 0; i < 31; i++)
         if ((1 << i) < v) r = i + 1;
      return (r < 1) ? 1 : r;
   endfunction

endpackage

// File: rtl/feature_map_stream_reader_frame_buffer_ram.sv
// Simple dual-port frame store: one write port, one registered
// read port, no reset so it maps onto block RAM.
module frame_buffer_ram
   import feature_map_stream_reader_pkg::*;
#(
   parameter int DATA_WIDHT = DATA_WIDHT_DFLT,
   parameter int DEPTH      = 900,
   localparam int AW        = clog2(DEPTH)
) (
   input  logic                  clk,
   input  logic                  wr_en,
   input  logic [AW-1:0]         wr_addr,
   input  logic [DATA_WIDHT-1:0] wr_data,
   input  logic                  rd_en,
   input  logic [AW-1:0]         rd_addr,
   output logic [DATA_WIDHT-1:0] rd_data
);

   logic [DATA_WIDHT-1:0] mem [DEPTH];

   always_ff @(posedge clk) begin
      if (wr_en) mem[wr_addr] <= wr_data;
      if (rd_en) rd_data <= mem[rd_addr];
   end

endmodule

// File: rtl/feature_map_stream_reader.sv
// Captures one convolution result frame, then replays it in raster
// order over valid/ready with a 2-entry skid register.
module feature_map_stream_reader
   import feature_map_stream_reader_pkg::*;
#(
   parameter int DATA_WIDHT = DATA_WIDHT_DFLT,
   parameter int IMG_WIDHT  = 30,
   parameter int IMG_HEIGHT = 30
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic [DATA_WIDHT-1:0] Data_In,
   input  logic                  Valid_In,
   input  logic                  Rd_Start,
   input  logic                  Rd_Ready,
   output logic [DATA_WIDHT-1:0] Data_Out,
   output logic                  Valid_Out,
   output logic                  Last_Out,
   output logic                  Frame_Full,
   output logic                  Overflow
);

   localparam int DEPTH = IMG_WIDHT * IMG_HEIGHT;
   localparam int AW    = clog2(DEPTH);
   localparam logic [AW-1:0] LAST_ADDR = AW'(DEPTH - 1);

   state_t                state, state_nx;
   logic [AW-1:0]         wr_addr, rd_addr;
   logic                  rd_end, rd_vld, rd_last;
   logic [DATA_WIDHT-1:0] rd_data, head_data, skid_data;
   logic                  head_v, head_last;
   logic                  skid_v, skid_last;
   logic                  wr_en, rd_en, pop, done, drop;
   logic [1:0]            occ;

   frame_buffer_ram #(
      .DATA_WIDHT (DATA_WIDHT),
      .DEPTH      (DEPTH)
   ) u_ram (
      .clk     (clk),
      .wr_en   (wr_en),
      .wr_addr (wr_addr),
      .wr_data (Data_In),
      .rd_en   (rd_en),
      .rd_addr (rd_addr),
      .rd_data (rd_data)
   );

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) state <= FILL;
      else      state <= state_nx;
   end

   always_comb begin
      state_nx = state;
      unique case (state)
         FILL:  if (wr_en && wr_addr == LAST_ADDR) state_nx = FULL;
         FULL:  if (Rd_Start) state_nx = DRAIN;
         DRAIN: if (done) state_nx = FILL;
         default: state_nx = FILL;
      endcase
   end

   // occ counts skid entries plus the read in flight; a read is only
   // issued when its word is sure to find a free skid slot.
   always_comb begin
      occ   = {1'b0, head_v} + {1'b0, skid_v} + {1'b0, rd_vld};
      pop   = head_v & Rd_Ready;
      done  = pop & head_last;
      wr_en = (state == FILL) & Valid_In;
      drop  = (state != FILL) & Valid_In;
      rd_en = (state == DRAIN) & ~rd_end &
              ((occ < 2'd2) | ((occ == 2'd2) & pop));
   end

   assign Frame_Full = (state == FULL);
   assign Data_Out   = head_data;
   assign Valid_Out  = head_v;
   assign Last_Out   = head_last;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         wr_addr  <= '0;
         rd_addr  <= '0;
         rd_end   <= 1'b0;
         rd_vld   <= 1'b0;
         rd_last  <= 1'b0;
         Overflow <= 1'b0;
      end else begin
         if (drop) Overflow <= 1'b1;
         if (done)
            wr_addr <= '0;
         else if (wr_en)
            wr_addr <= (wr_addr == LAST_ADDR) ? '0 : wr_addr + AW'(1);
         rd_vld <= rd_en;
         if (rd_en) rd_last <= (rd_addr == LAST_ADDR);
         if (state == FULL && Rd_Start) begin
            rd_addr <= '0;
            rd_end  <= 1'b0;
         end else if (rd_en) begin
            rd_addr <= rd_addr + AW'(1);
            if (rd_addr == LAST_ADDR) rd_end <= 1'b1;
         end
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         head_v    <= 1'b0;
         head_data <= '0;
         head_last <= 1'b0;
         skid_v    <= 1'b0;
         skid_data <= '0;
         skid_last <= 1'b0;
      end else if (pop) begin
         if (skid_v) begin
            head_data <= skid_data;
            head_last <= skid_last;
            skid_v    <= rd_vld;
            skid_data <= rd_data;
            skid_last <= rd_last;
         end else if (rd_vld) begin
            head_data <= rd_data;
            head_last <= rd_last;
         end else begin
            head_v    <= 1'b0;
            head_last <= 1'b0;
         end
      end else if (rd_vld) begin
         if (!head_v) begin
            head_v    <= 1'b1;
            head_data <= rd_data;
            head_last <= rd_last;
         end else begin
            skid_v    <= 1'b1;
            skid_data <= rd_data;
            skid_last <= rd_last;
         end
      end
   end

endmodule

// File: tb/tb_feature_map_stream_reader.sv
// Bench for feature_map_stream_reader on a 4x4 frame: table rows,
// hand-written corner sequences and random frames.
module tb_feature_map_stream_reader;

   localparam int DW = 32;
   localparam int N  = 16;

   logic          clk = 1'b0;
   logic          rst;
   logic [DW-1:0] Data_In;
   logic          Valid_In, Rd_Start, Rd_Ready;
   logic [DW-1:0] Data_Out;
   logic          Valid_Out, Last_Out, Frame_Full, Overflow;

   feature_map_stream_reader #(
      .DATA_WIDHT (DW),
      .IMG_WIDHT  (4),
      .IMG_HEIGHT (4)
   ) dut (
      .clk        (clk),
      .rst        (rst),
      .Data_In    (Data_In),
      .Valid_In   (Valid_In),
      .Rd_Start   (Rd_Start),
      .Rd_Ready   (Rd_Ready),
      .Data_Out   (Data_Out),
      .Valid_Out  (Valid_Out),
      .Last_Out   (Last_Out),
      .Frame_Full (Frame_Full),
      .Overflow   (Overflow)
   );

   always #5 clk = ~clk;

   typedef struct {
      int base;
      int gap;
      int rdy;
      bit poke;
      bit exp_ovf;
   } vec_t;

   int            checks = 0;
   int            errors = 0;
   logic [DW-1:0] frame [N];
   int            rpat [6] = '{1, 0, 0, 1, 0, 1};
   vec_t          vecs [5];
   bit            ovf_model;

   task automatic chk(input string name, input logic [DW-1:0] act,
                      input logic [DW-1:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual %0d required %0d", name, act, exp);
      end
   endtask

   task automatic fill(input int gap_mode, input bit mid_start);
      int g;
      for (int i = 0; i < N; i++) begin
         g = (i == 0) ? 0 : (gap_mode == 1) ? 1 :
             (gap_mode == 2) ? int'($urandom_range(0, 2)) : 0;
         repeat (g) begin
            @(negedge clk);
            Valid_In = 1'b0;
            Rd_Start = 1'b0;
            chk("ff_in_gap", Frame_Full, 0);
         end
         @(negedge clk);
         chk("ff_early", Frame_Full, 0);
         chk("vout_fill", Valid_Out, 0);
         Valid_In = 1'b1;
         Data_In  = frame[i];
         Rd_Start = mid_start && (i == N / 2);
      end
      @(negedge clk);
      Valid_In = 1'b0;
      Rd_Start = 1'b0;
      chk("frame_full", Frame_Full, 1);
   endtask

   task automatic poke();
      @(negedge clk);
      Valid_In = 1'b1;
      Data_In  = 99;
      @(negedge clk);
      Valid_In = 1'b0;
      chk("overflow_set", Overflow, 1);
      chk("ff_hold", Frame_Full, 1);
   endtask

   task automatic drain(input int rdy_mode, input int stop_after);
      int            idx, n, first, vcnt;
      bit            r, stalled;
      logic [DW-1:0] hold_d;
      logic          hold_l;
      idx = 0; n = 0; first = -1; vcnt = 0; stalled = 0;
      hold_d = '0; hold_l = 1'b0;
      @(negedge clk);
      Rd_Start = 1'b1;
      Rd_Ready = 1'b1;
      while (idx < stop_after && n < 400) begin
         @(negedge clk);
         Rd_Start = 1'b0;
         n++;
         if (Valid_Out && first < 0) begin
            first = n;
            chk("latency", n, 3);
         end
         if (stalled) begin
            chk("stall_data", Data_Out, hold_d);
            chk("stall_last", Last_Out, hold_l);
         end
         if (rdy_mode == 1)      r = rpat[vcnt % 6] != 0;
         else if (rdy_mode == 2) r = $urandom_range(0, 3) != 0;
         else                    r = 1'b1;
         if (Valid_Out) vcnt++;
         Rd_Ready = r;
         stalled  = Valid_Out && !r;
         hold_d   = Data_Out;
         hold_l   = Last_Out;
         if (Valid_Out && r) begin
            chk("data", Data_Out, frame[idx]);
            chk("last", Last_Out, idx == N - 1);
            idx++;
         end
      end
      if (n >= 400) chk("drain_timeout", idx, stop_after);
   endtask

   task automatic post_drain();
      @(negedge clk);
      Rd_Ready = 1'b0;
      chk("vout_after", Valid_Out, 0);
      chk("last_after", Last_Out, 0);
      chk("ff_after", Frame_Full, 0);
   endtask

   task automatic check_idle_outputs(input string tag);
      chk({tag, "_vout"}, Valid_Out, 0);
      chk({tag, "_dout"}, Data_Out, 0);
      chk({tag, "_last"}, Last_Out, 0);
      chk({tag, "_ff"}, Frame_Full, 0);
      chk({tag, "_ovf"}, Overflow, 0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog actual timeout required finish");
      $fatal(1, "watchdog");
   end

   initial begin
      rst      = 1'b1;
      Valid_In = 1'b0;
      Data_In  = '0;
      Rd_Start = 1'b0;
      Rd_Ready = 1'b0;
      #2 rst = 1'b0;
      #1 check_idle_outputs("reset");
      repeat (2) @(negedge clk);
      rst = 1'b1;

      vecs[0] = '{base: 1,   gap: 0, rdy: 0, poke: 0, exp_ovf: 0};
      vecs[1] = '{base: 1,   gap: 1, rdy: 0, poke: 0, exp_ovf: 0};
      vecs[2] = '{base: 1,   gap: 0, rdy: 1, poke: 0, exp_ovf: 0};
      vecs[3] = '{base: 1,   gap: 0, rdy: 0, poke: 1, exp_ovf: 1};
      vecs[4] = '{base: 200, gap: 1, rdy: 1, poke: 0, exp_ovf: 1};

      for (int v = 0; v < 5; v++) begin
         for (int i = 0; i < N; i++) frame[i] = DW'(vecs[v].base + i);
         fill(vecs[v].gap, 1'b0);
         if (vecs[v].poke) poke();
         drain(vecs[v].rdy, N);
         post_drain();
         chk("overflow_row", Overflow, vecs[v].exp_ovf);
      end

      // abort a replay part way through, then run a fresh frame
      for (int i = 0; i < N; i++) frame[i] = DW'(1 + i);
      fill(0, 1'b0);
      drain(0, 5);
      @(negedge clk);
      rst = 1'b0;
      #1 check_idle_outputs("mid_drain_rst");
      @(negedge clk);
      rst = 1'b1;
      for (int i = 0; i < N; i++) frame[i] = DW'(101 + i);
      fill(0, 1'b0);
      drain(0, N);
      post_drain();
      chk("overflow_cleared", Overflow, 0);

      for (int i = 0; i < N; i++) frame[i] = DW'(50 + i);
      fill(0, 1'b1);
      drain(0, N);
      post_drain();

      ovf_model = 1'b0;
      for (int t = 0; t < 4; t++) begin
         bit pk;
         for (int i = 0; i < N; i++) frame[i] = $urandom;
         pk = $urandom_range(0, 1) != 0;
         fill(2, 1'b0);
         if (pk) begin
            poke();
            ovf_model = 1'b1;
         end
         drain(2, N);
         post_drain();
         chk("overflow_rand", Overflow, ovf_model);
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
